riscv_v_element_sequencer: RTL and testbench
============================================

// Module: riscv_v_element_sequencer
// PURPOSE
//  Multi-cycle, LMUL-aware successor to the combinational vector decode element.
//  - Accepts one vector op descriptor: vl, vstart, vsew, LMUL, mask.
//  - Walks the register group one DATA_BYTES beat per register.
//  - Each beat emits per-byte valid/merge vectors and a one-hot osize to the vector ALU.
//  - Sits between vector decode and the ALU issue stage; uses valid/ready on both sides.
// PARAMETERS
//  DATA_BYTES  16  bytes per vector register (VLEN/8); power of 2
//  MAX_SEW     4   largest legal vsew code (0=8b .. 4=128b); 2**MAX_SEW <= DATA_BYTES
//  MAX_LMUL    8   largest register group size (1,2,4,8)
//  MAX_ELEMS   DATA_BYTES*MAX_LMUL  element capacity of a group; sets mask and vl widths
//  VL_W        $clog2(MAX_ELEMS)+1  width of vl/vstart
// PORTS
//  clk           in   1                      clock
//  rst_n         in   1                      synchronous active-low reset
//  req_valid     in   1                      descriptor valid
//  req_ready     out  1                      descriptor accepted when valid&ready
//  req_vl        in   VL_W                   vector length in elements
//  req_vstart    in   VL_W                   first active element
//  req_vsew      in   3                      element size code
//  req_lmul_log2 in   2                      group size = 2**req_lmul_log2 registers
//  req_use_mask  in   1                      apply req_mask
//  req_mask      in   MAX_ELEMS              one bit per element
//  beat_valid    out  1                      beat outputs valid
//  beat_ready    in   1                      ALU consumes beat
//  beat_reg      out  $clog2(MAX_LMUL)       register offset within group
//  beat_valid_b  out  DATA_BYTES             per-byte element-active vector
//  beat_merge    out  DATA_BYTES             byte b merges with byte b+1 (same element)
//  beat_osize    out  MAX_SEW+1              one-hot element size
//  beat_last     out  1                      final beat of descriptor
//  done          out  1                      one-cycle pulse, descriptor retired
//  err           out  1                      qualifies done: illegal vsew/lmul
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - State IDLE; beat_valid, done, err, beat_last = 0; all beat_* fields = 0.
//  - Reset mid-operation abandons the descriptor; no done pulse.
//  States:
//  - IDLE: req_ready=1. On accept, latch all req_* fields.
//    - Illegal descriptor (vsew>MAX_SEW, or 2**lmul_log2>MAX_LMUL) -> ERR.
//    - Empty descriptor (vl==0, or vstart>=vl) -> FIN.
//    - Otherwise -> BUSY.
//  - BUSY: req_ready=0; beat_valid=1.
//    - Beat fields stay stable while beat_valid & ~beat_ready.
//    - On beat handshake: if beat_last -> FIN, else beat_reg advances by 1.
//  - FIN: done=1 for one cycle -> IDLE.
//  - ERR: done=1 and err=1 for one cycle -> IDLE.
//  Beat range:
//  - EPR = DATA_BYTES>>vsew elements per register.
//  - First beat_reg = vstart/EPR.
//  - Final beat = min(2**lmul_log2-1, ceil(vl/EPR)-1).
//  - Registers wholly below vstart or at/after vl are never issued.
//  Per-byte fields:
//  - e = beat_reg*EPR + (b>>vsew).
//  - beat_valid_b[b] = (vstart<=e) & (e<vl) & (~use_mask | mask[e]).
//  - beat_merge[b] = ((b+1) % 2**vsew) != 0, so all zeros for vsew=0.
//  - beat_osize[vsew] = 1; all other bits 0.
//  Latency:
//  - First beat is valid the cycle after accept.
//  - With beat_ready held high: one beat per cycle, done one cycle after the last beat.
//  - One IDLE bubble between descriptors.
//  - Empty or illegal descriptor: done the cycle after accept, no beats.
//  Widths: all index arithmetic uses VL_W bits; vl > MAX_ELEMS is clamped to MAX_ELEMS.
// TESTING (DATA_BYTES=16)
//  1 vl=16, vsew=0, lmul=1, no mask
//    -> one beat: reg 0, valid_b=FFFF, merge=0000, osize=00001, last=1; done next cycle.
//  2 vl=10, vstart=3, vsew=1, lmul=4 (EPR=8)
//    -> beats reg0 valid_b=FFC0, reg1 valid_b=000F; reg2/3 skipped; merge=5555.
//  3 vl=4, vsew=2, use_mask, mask=...0101
//    -> valid_b=0F0F, merge=7777, osize=00100.
//  4 beat_ready held low 5 cycles mid-group
//    -> beat fields stable; no advance; req_ready stays 0.
//  5 vsew=5 -> no beats; done=1 & err=1 the cycle after accept.
//    vl=0 -> done=1, err=0.
//  6 rst_n low during beat 2 of 4 -> next cycle IDLE, beat_valid=0, no done.
//    A new request is accepted normally afterwards.

Source files
------------

// File: rtl/riscv_v_element_sequencer_if.sv
// Handshake bundle between vector decode, the element sequencer and the ALU issue stage.
// The master side (decode/ALU) drives descriptors and beat_ready; the slave side is the sequencer.
interface riscv_v_element_sequencer_if #(
    parameter int DATA_BYTES = 16,
    parameter int MAX_SEW    = 4,
    parameter int MAX_LMUL   = 8
);
    localparam int MAX_ELEMS = DATA_BYTES * MAX_LMUL;
    localparam int VL_W      = $clog2(MAX_ELEMS) + 1;
    localparam int REG_W     = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;
    localparam int OS_W      = MAX_SEW + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [VL_W-1:0]       req_vl;
    logic [VL_W-1:0]       req_vstart;
    logic [2:0]            req_vsew;
    logic [1:0]            req_lmul_log2;
    logic                  req_use_mask;
    logic [MAX_ELEMS-1:0]  req_mask;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [REG_W-1:0]      beat_reg;
    logic [DATA_BYTES-1:0] beat_valid_b;
    logic [DATA_BYTES-1:0] beat_merge;
    logic [OS_W-1:0]       beat_osize;
    logic                  beat_last;
    logic                  done;
    logic                  err;

    modport master (
        output req_valid, req_vl, req_vstart, req_vsew, req_lmul_log2, req_use_mask, req_mask,
        output beat_ready,
        input  req_ready, beat_valid, beat_reg, beat_valid_b, beat_merge, beat_osize,
        input  beat_last, done, err
    );

    modport slave (
        input  req_valid, req_vl, req_vstart, req_vsew, req_lmul_log2, req_use_mask, req_mask,
        input  beat_ready,
        output req_ready, beat_valid, beat_reg, beat_valid_b, beat_merge, beat_osize,
        output beat_last, done, err
    );
endinterface

// File: rtl/riscv_v_element_sequencer.sv
// LMUL-aware vector element sequencer: latches one descriptor and walks its register
// group one beat per register, emitting per-byte active/merge masks and one-hot element size.
module riscv_v_element_sequencer #(
    parameter int DATA_BYTES = 16,
    parameter int MAX_SEW    = 4,
    parameter int MAX_LMUL   = 8
) (
    input logic clk,
    input logic rst_n,
    riscv_v_element_sequencer_if.slave bus
);
    localparam int MAX_ELEMS = DATA_BYTES * MAX_LMUL;
    localparam int VL_W      = $clog2(MAX_ELEMS) + 1;
    localparam int REG_W     = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;
    localparam int OS_W      = MAX_SEW + 1;
    localparam int LOG_DB    = $clog2(DATA_BYTES);
    localparam int IDX_W     = VL_W - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]           state;
    logic [VL_W-1:0]      vl, vstart, sh, cur_reg, last_reg;
    logic [2:0]           vsew;
    logic                 use_mask;
    logic [MAX_ELEMS-1:0] mask;
    logic                 busy;

    // Descriptor decode, evaluated against the live request in IDLE
    logic [VL_W-1:0] a_vl, a_sh, a_first, a_ceil, a_final, a_grp_last;
    logic            a_illegal, a_empty;

    always_comb begin
        a_illegal  = (bus.req_vsew > 3'(MAX_SEW)) ||
                     ((32'd1 << bus.req_lmul_log2) > 32'(MAX_LMUL));
        a_vl       = (bus.req_vl > VL_W'(MAX_ELEMS)) ? VL_W'(MAX_ELEMS) : bus.req_vl;
        // log2 of elements-per-register; only meaningful for legal vsew
        a_sh       = VL_W'(LOG_DB) - VL_W'(bus.req_vsew);
        a_first    = bus.req_vstart >> a_sh;
        a_ceil     = (a_vl + (VL_W'(1) << a_sh) - VL_W'(1)) >> a_sh;
        a_grp_last = VL_W'((32'd1 << bus.req_lmul_log2) - 32'd1);
        a_final    = ((a_ceil - VL_W'(1)) < a_grp_last) ? (a_ceil - VL_W'(1)) : a_grp_last;
        // vstart beyond the group's last register leaves nothing to issue
        a_empty    = (a_vl == '0) || (bus.req_vstart >= a_vl) || (a_first > a_final);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vl       <= '0;
            vstart   <= '0;
            sh       <= '0;
            vsew     <= '0;
            use_mask <= 1'b0;
            mask     <= '0;
            cur_reg  <= '0;
            last_reg <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    vl       <= a_vl;
                    vstart   <= bus.req_vstart;
                    sh       <= a_sh;
                    vsew     <= bus.req_vsew;
                    use_mask <= bus.req_use_mask;
                    mask     <= bus.req_mask;
                    cur_reg  <= a_first;
                    last_reg <= a_final;
                    if (a_illegal)    state <= ERR;
                    else if (a_empty) state <= FIN;
                    else              state <= BUSY;
                end
                BUSY: if (bus.beat_ready) begin
                    if (cur_reg == last_reg) state <= FIN;
                    else                     cur_reg <= cur_reg + VL_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state == BUSY);
    assign bus.req_ready  = (state == IDLE);
    assign bus.beat_valid = busy;
    assign bus.beat_reg   = busy ? REG_W'(cur_reg) : '0;
    assign bus.beat_last  = busy && (cur_reg == last_reg);
    assign bus.beat_osize = busy ? (OS_W'(1) << vsew) : '0;
    assign bus.done       = (state == FIN) || (state == ERR);
    assign bus.err        = (state == ERR);

    for (genvar b = 0; b < DATA_BYTES; b++) begin : g_byte
        logic [VL_W-1:0] e;
        assign e = (cur_reg << sh) + (VL_W'(b) >> vsew);
        assign bus.beat_valid_b[b] = busy && (vstart <= e) && (e < vl) &&
                                     (!use_mask || mask[e[IDX_W-1:0]]);
        assign bus.beat_merge[b]   = busy &&
            ((VL_W'(b + 1) & ((VL_W'(1) << vsew) - VL_W'(1))) != '0);
    end
endmodule

// File: tb/tb_riscv_v_element_sequencer.sv
// Directed bench for riscv_v_element_sequencer with DATA_BYTES=16, MAX_LMUL=8.
module tb_riscv_v_element_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_v_element_sequencer_if #(.DATA_BYTES(16), .MAX_SEW(4), .MAX_LMUL(8)) bus();

    riscv_v_element_sequencer #(.DATA_BYTES(16), .MAX_SEW(4), .MAX_LMUL(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one descriptor for one cycle; returns at the negedge after acceptance
    task automatic send(input logic [7:0] vl, input logic [7:0] vstart, input logic [2:0] vsew,
                        input logic [1:0] lmul, input logic use_mask, input logic [127:0] mask);
        bus.req_valid     = 1'b1;
        bus.req_vl        = vl;
        bus.req_vstart    = vstart;
        bus.req_vsew      = vsew;
        bus.req_lmul_log2 = lmul;
        bus.req_use_mask  = use_mask;
        bus.req_mask      = mask;
        chk("req_ready_idle", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [2:0] r, input logic [15:0] vb,
                        input logic [15:0] mg, input logic [4:0] os, input logic last);
        chk({tag, "_valid"},   bus.beat_valid, 1'b1);
        chk({tag, "_reg"},     bus.beat_reg, r);
        chk({tag, "_valid_b"}, bus.beat_valid_b, vb);
        chk({tag, "_merge"},   bus.beat_merge, mg);
        chk({tag, "_osize"},   bus.beat_osize, os);
        chk({tag, "_last"},    bus.beat_last, last);
    endtask

    task automatic fin(input string tag, input logic e);
        chk({tag, "_done"},  bus.done, 1'b1);
        chk({tag, "_err"},   bus.err, e);
        chk({tag, "_nobeat"}, bus.beat_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        chk({tag, "_ready_back"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_vl = '0;
        bus.req_vstart = '0;
        bus.req_vsew = '0;
        bus.req_lmul_log2 = '0;
        bus.req_use_mask = 1'b0;
        bus.req_mask = '0;
        bus.beat_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_beat_valid", bus.beat_valid, 1'b0);
        chk("rst_done",       bus.done, 1'b0);
        chk("rst_err",        bus.err, 1'b0);
        chk("rst_last",       bus.beat_last, 1'b0);
        chk("rst_valid_b",    bus.beat_valid_b, 16'h0000);
        chk("rst_osize",      bus.beat_osize, 5'b00000);
        rst_n = 1'b1;
        @(negedge clk);

        // single full-register beat, 8-bit elements
        send(8'd16, 8'd0, 3'd0, 2'd0, 1'b0, '0);
        beat("t1", 3'd0, 16'hFFFF, 16'h0000, 5'b00001, 1'b1);
        @(negedge clk);
        fin("t1", 1'b0);

        // LMUL=4, 16-bit elements; trailing registers skipped
        send(8'd10, 8'd3, 3'd1, 2'd2, 1'b0, '0);
        beat("t2b0", 3'd0, 16'hFFC0, 16'h5555, 5'b00010, 1'b0);
        @(negedge clk);
        beat("t2b1", 3'd1, 16'h000F, 16'h5555, 5'b00010, 1'b1);
        @(negedge clk);
        fin("t2", 1'b0);

        // masked 32-bit elements
        send(8'd4, 8'd0, 3'd2, 2'd0, 1'b1, 128'h5);
        beat("t3", 3'd0, 16'h0F0F, 16'h7777, 5'b00100, 1'b1);
        @(negedge clk);
        fin("t3", 1'b0);

        // back-pressure mid-group
        send(8'd60, 8'd0, 3'd0, 2'd2, 1'b0, '0);
        beat("t4b0", 3'd0, 16'hFFFF, 16'h0000, 5'b00001, 1'b0);
        @(negedge clk);
        bus.beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat("t4hold", 3'd1, 16'hFFFF, 16'h0000, 5'b00001, 1'b0);
            chk("t4hold_req_ready", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        bus.beat_ready = 1'b1;
        beat("t4b1", 3'd1, 16'hFFFF, 16'h0000, 5'b00001, 1'b0);
        @(negedge clk);
        beat("t4b2", 3'd2, 16'hFFFF, 16'h0000, 5'b00001, 1'b0);
        @(negedge clk);
        beat("t4b3", 3'd3, 16'h0FFF, 16'h0000, 5'b00001, 1'b1);
        @(negedge clk);
        fin("t4", 1'b0);

        // illegal vsew, empty vl, vstart>=vl
        send(8'd5, 8'd0, 3'd5, 2'd0, 1'b0, '0);
        fin("t5ill", 1'b1);
        send(8'd0, 8'd0, 3'd0, 2'd0, 1'b0, '0);
        fin("t5vl0", 1'b0);
        send(8'd5, 8'd5, 3'd0, 2'd0, 1'b0, '0);
        fin("t5vst", 1'b0);

        // vl above capacity clamps to 128; only the last register of an LMUL=8 group issues
        send(8'd200, 8'd120, 3'd0, 2'd3, 1'b0, '0);
        beat("tclamp", 3'd7, 16'hFF00, 16'h0000, 5'b00001, 1'b1);
        @(negedge clk);
        fin("tclamp", 1'b0);

        // reset during beat 2 of 4
        send(8'd64, 8'd0, 3'd0, 2'd2, 1'b0, '0);
        @(negedge clk);
        beat("t6b1", 3'd1, 16'hFFFF, 16'h0000, 5'b00001, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", bus.beat_valid, 1'b0);
        chk("t6_rst_done",  bus.done, 1'b0);
        chk("t6_rst_ready", bus.req_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_done", bus.done, 1'b0);

        // widest element after reset: one element fills the register
        send(8'd1, 8'd0, 3'd4, 2'd0, 1'b0, '0);
        beat("t6new", 3'd0, 16'hFFFF, 16'h7FFF, 5'b10000, 1'b1);
        @(negedge clk);
        fin("t6new", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
